// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: h/v counters, decoded sync/enable strobes
// delayed LOOKAHEAD+1 pixels behind the coordinates, and a completed-frame counter.
module video_timing_gen #(
  parameter int H_ACTIVE  = 1280,
  parameter int H_FP      = 48,
  parameter int H_SYNC    = 112,
  parameter int H_BP      = 248,
  parameter int V_ACTIVE  = 1024,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 3,
  parameter int V_BP      = 38,
  parameter int HS_POL    = 1,
  parameter int VS_POL    = 1,
  parameter int CW        = 11,
  parameter int LOOKAHEAD = 2,
  parameter int FCW       = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ce,
  output logic [CW-1:0]  x,
  output logic [CW-1:0]  y,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic           line_start,
  output logic           frame_start,
  output logic [FCW-1:0] frame_count
);

  localparam int HTOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VTOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int D      = LOOKAHEAD + 1;

  if ((HTOTAL - 1) >= (1 << CW) || (VTOTAL - 1) >= (1 << CW)) begin : g_cw_too_small
    $error("video_timing_gen: CW too small for HTOTAL-1 / VTOTAL-1");
  end
  if (LOOKAHEAD < 0 || LOOKAHEAD > 15) begin : g_lookahead_range
    $error("video_timing_gen: LOOKAHEAD out of range 0..15");
  end

  localparam logic [CW-1:0] H_LAST   = CW'(HTOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(VTOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic          HS_POL_B = (HS_POL != 0);
  localparam logic          VS_POL_B = (VS_POL != 0);

  // Pipeline word bit positions
  localparam int B_DE = 0;
  localparam int B_HS = 1;
  localparam int B_VS = 2;
  localparam int B_LS = 3;
  localparam int B_FS = 4;

  logic [CW-1:0]       h_q, h_d;
  logic [CW-1:0]       v_q, v_d;
  logic [FCW-1:0]      fc_q, fc_d;
  logic [D-1:0][4:0]   pipe_q, pipe_d;
  logic [4:0]          dec;

  always_comb begin
    dec       = '0;
    dec[B_DE] = (h_q < H_ACT_C) && (v_q < V_ACT_C);
    dec[B_HS] = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
    dec[B_VS] = (v_q >= VS_FIRST) && (v_q <= VS_LAST);
    dec[B_LS] = (h_q == '0);
    dec[B_FS] = (h_q == '0) && (v_q == '0);
  end

  always_comb begin
    h_d    = h_q;
    v_d    = v_q;
    fc_d   = fc_q;
    pipe_d = pipe_q;
    if (ce) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d  = '0;
          fc_d = fc_q + 1'b1;
        end else begin
          v_d = v_q + 1'b1;
        end
      end else begin
        h_d = h_q + 1'b1;
      end
      pipe_d[0] = dec;
      for (int i = 1; i < D; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q    <= '0;
      v_q    <= '0;
      fc_q   <= '0;
      pipe_q <= '0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      fc_q   <= fc_d;
      pipe_q <= pipe_d;
    end
  end

  // Cleared pipeline yields the deasserted sync level for either polarity.
  assign x           = h_q;
  assign y           = v_q;
  assign frame_count = fc_q;
  assign de          = pipe_q[D-1][B_DE];
  assign line_start  = pipe_q[D-1][B_LS];
  assign frame_start = pipe_q[D-1][B_FS];
  assign hsync       = pipe_q[D-1][B_HS] ^ ~HS_POL_B;
  assign vsync       = pipe_q[D-1][B_VS] ^ ~VS_POL_B;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: two small-geometry instances (LOOKAHEAD 0 and 2) checked every
// cycle against hand-tabulated decode, plus a default-geometry instance for start-up.
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic ce;

  always #5 clk = ~clk;

  logic [3:0] x_a, y_a, x_b, y_b;
  logic       hs_a, vs_a, de_a, ls_a, fs_a;
  logic       hs_b, vs_b, de_b, ls_b, fs_b;
  logic [1:0] fc_a;
  logic [7:0] fc_b;
  logic [10:0] x_c, y_c;
  logic        hs_c, vs_c, de_c, ls_c, fs_c;
  logic [7:0]  fc_c;

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(0), .VS_POL(1), .CW(4), .LOOKAHEAD(0), .FCW(2)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .ce(ce), .x(x_a), .y(y_a), .hsync(hs_a), .vsync(vs_a),
    .de(de_a), .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a)
  );

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(0), .CW(4), .LOOKAHEAD(2), .FCW(8)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .ce(ce), .x(x_b), .y(y_b), .hsync(hs_b), .vsync(vs_b),
    .de(de_b), .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b)
  );

  video_timing_gen u_c (
    .clk(clk), .rst_n(rst_n), .ce(ce), .x(x_c), .y(y_c), .hsync(hs_c), .vsync(vs_c),
    .de(de_c), .line_start(ls_c), .frame_start(fs_c), .frame_count(fc_c)
  );

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  obs_t oa, ob;
  assign oa = {x_a, y_a, hs_a, vs_a, de_a, ls_a, fs_a, 6'b0, fc_a};
  assign ob = {x_b, y_b, hs_b, vs_b, de_b, ls_b, fs_b, fc_b};

  obs_t q_a[$];
  obs_t q_b[$];

  int n_vec = 0;
  int n_err = 0;

  // Hand tables for the 8x6 raster (bit index = h or v), asserted levels.
  logic [7:0] h_de_t = 8'b0000_1111;
  logic [7:0] h_hs_t = 8'b0110_0000;
  logic [5:0] v_ac_t = 6'b000111;
  logic [5:0] v_vs_t = 6'b010000;

  int         mh, mv, mfc;
  logic [4:0] mpa;
  logic [4:0] mpb [3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // {fs, ls, vs, hs, de}
  function automatic logic [4:0] mdec(input int h, input int v);
    return {(h == 0 && v == 0), (h == 0), v_vs_t[v], h_hs_t[h], h_de_t[h] & v_ac_t[v]};
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0; mfc = 0; mpa = '0;
    for (int i = 0; i < 3; i++) mpb[i] = '0;
  endtask

  task automatic model_edge(input logic c);
    if (c) begin
      mpb[2] = mpb[1];
      mpb[1] = mpb[0];
      mpb[0] = mdec(mh, mv);
      mpa    = mdec(mh, mv);
      if (mh == 7) begin
        mh = 0;
        if (mv == 5) begin mv = 0; mfc++; end
        else mv++;
      end else begin
        mh++;
      end
    end
  endtask

  function automatic obs_t exp_a();
    return {mh[3:0], mv[3:0], ~mpa[1], mpa[2], mpa[0], mpa[3], mpa[4], 6'b0, mfc[1:0]};
  endfunction

  function automatic obs_t exp_b();
    return {mh[3:0], mv[3:0], mpb[2][1], ~mpb[2][2], mpb[2][0], mpb[2][3], mpb[2][4], mfc[7:0]};
  endfunction

  task automatic step(input logic c);
    ce = c;
    @(posedge clk);
    #1;
    model_edge(c);
    q_a.push_back(exp_a());
    q_b.push_back(exp_b());
  endtask

  always @(negedge clk) begin
    if (q_a.size() > 0) chk("obs_a", 64'(oa), 64'(q_a.pop_front()));
    if (q_b.size() > 0) chk("obs_b", 64'(ob), 64'(q_b.pop_front()));
  end

  logic [31:0] pat = 32'b1101_0011_1110_0101_1011_0001_1111_0110;

  initial begin
    rst_n = 1'b1;
    ce    = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    chk("reset_a", 64'(oa), 64'(exp_a()));
    chk("reset_b", 64'(ob), 64'(exp_b()));
    chk("reset_c", 64'({x_c, y_c, hs_c, vs_c, de_c, ls_c, fs_c, fc_c}), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Four frames at full rate
    for (int i = 0; i < 192; i++) begin
      step(1'b1);
      if (i == 0) chk("a_fs_edge1", 64'({fs_a, fs_b}), 64'b10);
      if (i == 1) chk("c_fs_edge2", 64'({fs_c, de_c}), 64'b00);
      if (i == 2) begin
        chk("b_fs_edge3", 64'({fs_b, ls_b, de_b}), 64'b111);
        chk("c_fs_edge3", 64'({fs_c, de_c, ls_c, hs_c, x_c}), {49'b0, 4'b1110, 11'd3});
      end
      if (i == 4) chk("a_hs_h4", 64'(hs_a), 64'd1);
      if (i == 5) chk("a_hs_h5", 64'(hs_a), 64'd0);
      if (i == 6) chk("a_hs_h6", 64'(hs_a), 64'd0);
      if (i == 7) chk("a_hs_h7", 64'(hs_a), 64'd1);
    end
    chk("fc_after_4_frames", 64'({fc_b, 6'b0, fc_a}), 64'h0400);

    // Half-rate ce: one frame over 96 clocks, pulses held across ce=0
    for (int i = 0; i < 96; i++) step((i % 2) == 0);
    chk("fc_after_half_rate", 64'({fc_b, 6'b0, fc_a}), 64'h0501);

    for (int i = 0; i < 32; i++) step(pat[i]);

    begin
      int n = 0;
      while (hs_b !== 1'b1 && n < 20) begin
        step(1'b1);
        n++;
      end
      chk("wait_hsync_b", 64'(hs_b), 64'd1);
    end
    @(negedge clk);
    #1 rst_n = 1'b0;
    ce = 1'b0;
    #1;
    model_reset();
    chk("rst_mid_a", 64'(oa), 64'(exp_a()));
    chk("rst_mid_b", 64'(ob), 64'(exp_b()));
    chk("rst_mid_b_sync", 64'({hs_b, vs_b, de_b, x_b, y_b}), 64'b010_0000_0000);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 60; i++) step(1'b1);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
